// File: rtl/ws_pulse_decoder.sv
// Receive-side decoder for the single-wire pulse-width LED protocol.
// Measures high/low widths, classifies bits, assembles 24-bit pixels.
module ws_pulse_decoder #(
  parameter int T0H_MIN = 4,
  parameter int T0H_MAX = 10,
  parameter int T1H_MIN = 11,
  parameter int T1H_MAX = 17,
  parameter int T0L_MIN = 13,
  parameter int T0L_MAX = 19,
  parameter int T1L_MIN = 9,
  parameter int T1L_MAX = 15,
  parameter int TRESET  = 1000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_din,
  output logic [23:0]      o_pixel_data,
  output logic             o_pixel_valid,
  output logic             o_frame_end,
  output logic             o_bit_error,
  output logic [CNT_W-1:0] o_pixel_count
);

  localparam logic [CNT_W-1:0] C_T0H_MIN = CNT_W'(T0H_MIN);
  localparam logic [CNT_W-1:0] C_T0H_MAX = CNT_W'(T0H_MAX);
  localparam logic [CNT_W-1:0] C_T1H_MIN = CNT_W'(T1H_MIN);
  localparam logic [CNT_W-1:0] C_T1H_MAX = CNT_W'(T1H_MAX);
  localparam logic [CNT_W-1:0] C_T0L_MIN = CNT_W'(T0L_MIN);
  localparam logic [CNT_W-1:0] C_T0L_MAX = CNT_W'(T0L_MAX);
  localparam logic [CNT_W-1:0] C_T1L_MIN = CNT_W'(T1L_MIN);
  localparam logic [CNT_W-1:0] C_T1L_MAX = CNT_W'(T1L_MAX);
  localparam logic [CNT_W-1:0] C_TRESET  = CNT_W'(TRESET);
  localparam logic [CNT_W-1:0] C_SAT     = {CNT_W{1'b1}};
  localparam logic [4:0]       LAST_IDX  = 5'd23;

  typedef enum logic [2:0] {
    WAIT_RST = 3'd0,
    IDLE     = 3'd1,
    HIGH     = 3'd2,
    LOW      = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             din_meta;
  logic             din_s;
  logic             din_prev;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;

  logic             pend_bit;
  logic [23:0]      shreg;
  logic [4:0]       bit_idx;

  logic             hi_is0;
  logic             hi_is1;
  logic             lo_ok;
  logic             gap_hit;
  logic             gap_held;
  logic             hi_over;

  logic             pend_set;
  logic             pend_val;
  logic             shift_en;
  logic             fe_hit;
  logic             err_enter;
  logic             pix_done;
  logic             partial;
  logic [4:0]       idx_after;
  logic [23:0]      sh_next;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_prev <= 1'b0;
    end else begin
      din_meta <= i_din;
      din_s    <= din_meta;
      din_prev <= din_s;
    end
  end

  assign rise = din_s & ~din_prev;
  assign fall = ~din_s & din_prev;

  // Saturating width counter: restarts at 1 on every level change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (din_s != din_prev) begin
      cnt <= CNT_W'(1);
    end else if (cnt != C_SAT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Width classification against the tolerance windows
  always_comb begin
    hi_is0   = (cnt >= C_T0H_MIN) && (cnt <= C_T0H_MAX);
    hi_is1   = (cnt >= C_T1H_MIN) && (cnt <= C_T1H_MAX);
    hi_over  = (cnt > C_T1H_MAX);
    if (pend_bit) begin
      lo_ok = (cnt >= C_T1L_MIN) && (cnt <= C_T1L_MAX);
    end else begin
      lo_ok = (cnt >= C_T0L_MIN) && (cnt <= C_T0L_MAX);
    end
    gap_hit  = ~din_s && ~din_prev && (cnt == C_TRESET);
    gap_held = ~din_s && ~din_prev && (cnt >= C_TRESET);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_RST: begin
        if (gap_held) state_nxt = IDLE;
      end
      IDLE: begin
        if (gap_hit) state_nxt = IDLE;
        else if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if (hi_is0 || hi_is1) state_nxt = LOW;
          else state_nxt = ERROR;
        end else if (hi_over) begin
          state_nxt = ERROR;
        end
      end
      LOW: begin
        if (gap_hit) state_nxt = IDLE;
        else if (rise) state_nxt = lo_ok ? HIGH : ERROR;
      end
      ERROR: state_nxt = WAIT_RST;
      default: state_nxt = WAIT_RST;
    endcase
  end

  // Per-state datapath actions
  always_comb begin
    pend_set  = 1'b0;
    pend_val  = 1'b0;
    shift_en  = 1'b0;
    fe_hit    = 1'b0;
    unique case (1'b1)
      (state == HIGH): begin
        pend_set = fall;
        pend_val = hi_is1;
      end
      (state == LOW): begin
        shift_en = gap_hit || (rise && lo_ok);
        fe_hit   = gap_hit;
      end
      (state == IDLE): begin
        fe_hit = gap_hit;
      end
      default: begin
        pend_set = 1'b0;
      end
    endcase
    err_enter = (state_nxt == ERROR) && (state != ERROR);
    sh_next   = {shreg[22:0], pend_bit};
    pix_done  = shift_en && (bit_idx == LAST_IDX);
    if (!shift_en) idx_after = bit_idx;
    else if (bit_idx == LAST_IDX) idx_after = 5'd0;
    else idx_after = bit_idx + 5'd1;
    partial = fe_hit && (idx_after != 5'd0);
  end

  // Pending bit latched at the falling edge of each high pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_bit <= 1'b0;
    end else if (pend_set) begin
      pend_bit <= pend_val;
    end
  end

  // Shift register and bit index; dropped on error or frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (state == ERROR || fe_hit) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (shift_en) begin
      shreg   <= sh_next;
      bit_idx <= idx_after;
    end
  end

  // Registered output pulses and pixel data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pixel_data  <= '0;
      o_pixel_valid <= 1'b0;
      o_frame_end   <= 1'b0;
      o_bit_error   <= 1'b0;
    end else begin
      o_pixel_valid <= pix_done;
      o_frame_end   <= fe_hit;
      o_bit_error   <= err_enter || partial;
      if (pix_done) o_pixel_data <= sh_next;
    end
  end

  // Pixel counter: holds through frame_end, clears the cycle after
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pixel_count <= '0;
    end else if (o_frame_end || state == ERROR) begin
      o_pixel_count <= '0;
    end else if (pix_done && o_pixel_count != C_SAT) begin
      o_pixel_count <= o_pixel_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ws_pulse_decoder.sv
// Self-checking bench for ws_pulse_decoder.
// Expected events queue at stimulus time, popped by an output monitor.
module tb_ws_pulse_decoder;

  localparam int CNT_W = 16;
  localparam int K_PIX = 0;
  localparam int K_FE  = 1;
  localparam int K_ERR = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_din;
  logic [23:0]      o_pixel_data;
  logic             o_pixel_valid;
  logic             o_frame_end;
  logic             o_bit_error;
  logic [CNT_W-1:0] o_pixel_count;

  typedef struct {
    int          kind;
    logic [23:0] data;
    int          cnt;
    logic        err;
  } ev_t;

  ev_t q[$];
  int  n_pass = 0;
  int  n_total = 0;
  bit  fe_prev = 1'b0;

  ws_pulse_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .i_din         (i_din),
    .o_pixel_data  (o_pixel_data),
    .o_pixel_valid (o_pixel_valid),
    .o_frame_end   (o_frame_end),
    .o_bit_error   (o_bit_error),
    .o_pixel_count (o_pixel_count)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every DUT event
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      fe_prev = 1'b0;
    end else begin
      if (fe_prev) begin
        n_total++;
        if (int'(o_pixel_count) !== 0)
          $display("FAIL count_clear: got %0d want 0", o_pixel_count);
        else n_pass++;
      end
      fe_prev = o_frame_end;
      if (o_pixel_valid) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_pixel: got %h", o_pixel_data);
        end else begin
          e = q.pop_front();
          if (e.kind !== K_PIX || e.data !== o_pixel_data ||
              e.cnt != int'(o_pixel_count))
            $display("FAIL pixel: got data=%h cnt=%0d want kind=%0d data=%h cnt=%0d",
                     o_pixel_data, o_pixel_count, e.kind, e.data, e.cnt);
          else n_pass++;
        end
      end
      if (o_frame_end) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_frame_end: got err=%0b", o_bit_error);
        end else begin
          e = q.pop_front();
          if (e.kind !== K_FE || e.err !== o_bit_error ||
              e.cnt != int'(o_pixel_count))
            $display("FAIL frame_end: got err=%0b cnt=%0d want kind=%0d err=%0b cnt=%0d",
                     o_bit_error, o_pixel_count, e.kind, e.err, e.cnt);
          else n_pass++;
        end
      end else if (o_bit_error) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_bit_error: got 1 want 0");
        end else begin
          e = q.pop_front();
          if (e.kind !== K_ERR)
            $display("FAIL bit_error: got error want kind=%0d", e.kind);
          else n_pass++;
        end
      end
    end
  end

  task automatic push_ev(int kind, logic [23:0] d, int c, logic er);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.cnt  = c;
    e.err  = er;
    q.push_back(e);
  endtask

  task automatic send_hl(int h, int l);
    i_din = 1'b1;
    repeat (h) @(negedge clk);
    i_din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(logic b);
    if (b) send_hl(14, 12);
    else send_hl(7, 16);
  endtask

  task automatic send_bits(logic [23:0] p, int nbits);
    for (int i = 23; i > 23 - nbits; i--) send_bit(p[i]);
  endtask

  task automatic gap();
    i_din = 1'b0;
    repeat (1010) @(negedge clk);
  endtask

  task automatic check_drained(string name);
    n_total++;
    if (q.size() != 0)
      $display("FAIL %s: got %0d pending events want 0", name, q.size());
    else n_pass++;
  endtask

  task automatic check_idle_outputs(string name);
    n_total++;
    if (o_pixel_data !== 24'h0 || o_pixel_valid !== 1'b0 ||
        o_frame_end !== 1'b0 || o_bit_error !== 1'b0 ||
        o_pixel_count !== '0)
      $display("FAIL %s: got data=%h v=%0b fe=%0b err=%0b cnt=%0d want all 0",
               name, o_pixel_data, o_pixel_valid, o_frame_end,
               o_bit_error, o_pixel_count);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_din = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_single_pixel();
    gap();
    push_ev(K_PIX, 24'hA5C3F0, 1, 1'b0);
    push_ev(K_FE, 24'h0, 1, 1'b0);
    send_bits(24'hA5C3F0, 24);
    gap();
    check_drained("single_pixel");
  endtask

  task automatic test_pre_gap_ignored();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bits(24'h123456, 24);
    gap();
    check_drained("pre_gap_ignored");
    push_ev(K_PIX, 24'hA5C3F0, 1, 1'b0);
    push_ev(K_FE, 24'h0, 1, 1'b0);
    send_bits(24'hA5C3F0, 24);
    gap();
    check_drained("post_gap_decode");
  endtask

  task automatic test_window_edges();
    logic [23:0] p;
    int h;
    p = 24'h5A3C96;
    push_ev(K_PIX, p, 1, 1'b0);
    push_ev(K_FE, 24'h0, 1, 1'b0);
    for (int i = 23; i >= 0; i--) begin
      if (p[i]) h = (i % 2 == 1) ? 11 : 17;
      else h = (i % 2 == 1) ? 4 : 10;
      send_hl(h, p[i] ? 12 : 16);
    end
    gap();
    check_drained("high_edges_ok");
    push_ev(K_ERR, 24'h0, 0, 1'b1);
    send_bits(24'hA5C3F0, 5);
    send_hl(3, 16);
    send_bits(24'hFFFFFF, 18);
    gap();
    check_drained("high_3_error");
    push_ev(K_ERR, 24'h0, 0, 1'b1);
    send_bits(24'hA5C3F0, 3);
    send_hl(18, 12);
    send_bits(24'h0F0F0F, 20);
    gap();
    check_drained("high_18_error");
  endtask

  task automatic test_low_windows();
    logic [23:0] p;
    int l;
    p = 24'h3CA569;
    push_ev(K_PIX, p, 1, 1'b0);
    push_ev(K_FE, 24'h0, 1, 1'b0);
    for (int i = 23; i >= 0; i--) begin
      if (p[i]) l = (i % 2 == 1) ? 9 : 15;
      else l = (i % 2 == 1) ? 13 : 19;
      send_hl(p[i] ? 14 : 7, l);
    end
    gap();
    check_drained("low_edges_ok");
    push_ev(K_ERR, 24'h0, 0, 1'b1);
    send_bits(24'hC00000, 2);
    send_hl(7, 12);
    send_bits(24'hFFFFFF, 21);
    gap();
    check_drained("low0_short_error");
    push_ev(K_ERR, 24'h0, 0, 1'b1);
    send_bits(24'h000000, 4);
    send_hl(14, 16);
    send_bits(24'hAAAAAA, 19);
    gap();
    check_drained("low1_long_error");
  endtask

  task automatic test_back_to_back();
    push_ev(K_PIX, 24'h010203, 1, 1'b0);
    push_ev(K_PIX, 24'hFEDCBA, 2, 1'b0);
    push_ev(K_PIX, 24'h800001, 3, 1'b0);
    push_ev(K_FE, 24'h0, 3, 1'b0);
    send_bits(24'h010203, 24);
    send_bits(24'hFEDCBA, 24);
    send_bits(24'h800001, 24);
    gap();
    check_drained("back_to_back");
  endtask

  task automatic test_partial();
    push_ev(K_FE, 24'h0, 0, 1'b1);
    send_bits(24'hB7E151, 10);
    gap();
    check_drained("partial_pixel");
  endtask

  task automatic test_reset_mid_frame();
    send_bits(24'h6C9E3D, 11);
    i_din = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    i_din = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("mid_frame_reset");
    rst = 1'b0;
    send_bits(24'hFFFFFF, 4);
    gap();
    check_drained("after_mid_reset_ignored");
    push_ev(K_PIX, 24'h6C9E3D, 1, 1'b0);
    push_ev(K_FE, 24'h0, 1, 1'b0);
    send_bits(24'h6C9E3D, 24);
    gap();
    check_drained("after_mid_reset_decode");
  endtask

  initial begin
    rst = 1'b1;
    i_din = 1'b0;
    test_reset();
    test_single_pixel();
    test_pre_gap_ignored();
    test_window_edges();
    test_low_windows();
    test_back_to_back();
    test_partial();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
